// File: rtl/imem_responder.sv
// imem_responder: responder end of the instruction-fetch data bus.
//
// A program image is streamed in over a valid/ready load port. Once the last
// word arrives, or storage is full, the block raises `run`. From then on it
// returns mem[data_bus_addr] every cycle after READ_LATENCY cycles, fully
// pipelined.
//
// Optional feature: define IMEM_RELOAD_EN so that `reload` sends RUN back to
// LOAD. Without the macro, `reload` is ignored.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-low
//   data_bus_addr in   fetch address (word addressed), sampled every cycle
//   data_bus_data out  fetched word (0 in LOAD, and 0 for out-of-range addresses)
//   load_valid    in   load word present
//   load_ready    out  responder accepts a load word (high in LOAD)
//   load_data     in   load word
//   load_last     in   final image word, qualified by load_valid
//   reload        in   return to LOAD (only with IMEM_RELOAD_EN)
//   run           out  image loaded; core may fetch
//   fault         out  sticky; an unloaded or out-of-range word was fetched
//   load_count    out  words loaded
//   fetch_count   out  in-range fetches in RUN, saturating
//
// Parameters: READ_LATENCY is legal from 1 to 4. MEMORY_DEPTH must be a power
// of two and at least 4.

module imem_responder #(
  parameter int DATA_BUS_DATA_BITS = 32,
  parameter int DATA_BUS_ADDR_BITS = 32,
  parameter int MEMORY_DEPTH       = 1024,
  parameter int READ_LATENCY       = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DATA_BUS_ADDR_BITS-1:0]     data_bus_addr,
  output logic [DATA_BUS_DATA_BITS-1:0]     data_bus_data,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [DATA_BUS_DATA_BITS-1:0]     load_data,
  input  logic                              load_last,
  input  logic                              reload,
  output logic                              run,
  output logic                              fault,
  output logic [$clog2(MEMORY_DEPTH):0]     load_count,
  output logic [31:0]                       fetch_count
);

  localparam int IDXW = $clog2(MEMORY_DEPTH);
  localparam int CNTW = IDXW + 1;
  // The range compare uses the wider of address and count, so no upper address
  // bit is dropped. An aliasing address therefore cannot appear in range.
  localparam int CMPW = (DATA_BUS_ADDR_BITS > CNTW) ? DATA_BUS_ADDR_BITS : CNTW;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                          state;
  logic [DATA_BUS_DATA_BITS-1:0]   mem [MEMORY_DEPTH];
  logic [DATA_BUS_DATA_BITS-1:0]   rd_pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0]         oor_pipe;

  logic                            load_fire;
  logic                            load_done;
  logic                            fetch_oor;
  logic [DATA_BUS_DATA_BITS-1:0]   stage_data;
  logic                            stage_oor;
  logic                            oor_to_out;
  logic                            reload_hit;

  assign load_fire  = (state == S_LOAD) && load_valid;
  // Filling the last slot counts as an implicit load_last.
  assign load_done  = load_fire && (load_last || (load_count == CNTW'(MEMORY_DEPTH - 1)));
  assign fetch_oor  = CMPW'(data_bus_addr) >= CMPW'(load_count);

  // The index is only used when the address is in range. In that case the
  // address is below load_count, which is at most MEMORY_DEPTH, so the
  // truncation is safe.
  assign stage_data = (state == S_RUN && !fetch_oor) ? mem[data_bus_addr[IDXW-1:0]]
                                                     : '0;
  assign stage_oor  = (state == S_RUN) && fetch_oor;

  assign data_bus_data = rd_pipe[READ_LATENCY-1];

  // The out-of-range flag travels beside its zero word. fault is set on the
  // same edge that the zero reaches data_bus_data.
  generate
    if (READ_LATENCY == 1) begin : g_oor_l1
      assign oor_to_out = stage_oor;
    end else begin : g_oor_ln
      assign oor_to_out = oor_pipe[READ_LATENCY-2];
    end
  endgenerate

`ifdef IMEM_RELOAD_EN
  assign reload_hit = (state == S_RUN) && reload;
`else
  logic unused_reload;
  assign unused_reload = reload;
  assign reload_hit    = 1'b0;
`endif

  // Storage is never cleared. Words from an abandoned load stay in the array,
  // but they are not reachable because the range check uses load_count.
  always_ff @(posedge clock) begin
    if (reset && load_fire)
      mem[load_count[IDXW-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_LOAD;
      load_ready  <= 1'b1;
      run         <= 1'b0;
      fault       <= 1'b0;
      load_count  <= '0;
      fetch_count <= '0;
      oor_pipe    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
    end else if (reload_hit) begin
      // Drop any in-flight words. fault and fetch_count are kept.
      state      <= S_LOAD;
      load_ready <= 1'b1;
      run        <= 1'b0;
      load_count <= '0;
      oor_pipe   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0]  <= stage_data;
      oor_pipe[0] <= stage_oor;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i]  <= rd_pipe[i-1];
        oor_pipe[i] <= oor_pipe[i-1];
      end
      fault <= fault | oor_to_out;

      case (state)
        S_LOAD: begin
          if (load_fire) begin
            load_count <= load_count + CNTW'(1);
            if (load_done) begin
              state      <= S_RUN;
              load_ready <= 1'b0;
              run        <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!fetch_oor && fetch_count != '1)
            fetch_count <= fetch_count + 32'd1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder. It runs two instances side by side,
// one with READ_LATENCY=1 and one with READ_LATENCY=3, from shared stimulus.
// Stimulus pushes expected values, each tagged with the cycle it is due. A
// negedge monitor compares the items that fall due.
module tb_imem_responder;
  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_bus_addr;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        reload;

  logic [31:0] d1, d3, fc1, fc3;
  logic        ready1, ready3, run1, run3, fault1, fault3;
  logic [10:0] lc1, lc3;

  imem_responder #(.MEMORY_DEPTH(DEPTH), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .data_bus_addr(data_bus_addr), .data_bus_data(d1),
    .load_valid(load_valid), .load_ready(ready1), .load_data(load_data),
    .load_last(load_last), .reload(reload), .run(run1), .fault(fault1),
    .load_count(lc1), .fetch_count(fc1));

  imem_responder #(.MEMORY_DEPTH(DEPTH), .READ_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .data_bus_addr(data_bus_addr), .data_bus_data(d3),
    .load_valid(load_valid), .load_ready(ready3), .load_data(load_data),
    .load_last(load_last), .reload(reload), .run(run3), .fault(fault3),
    .load_count(lc3), .fetch_count(fc3));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   drain_check = 0;
  bit   drain_done  = 0;
  logic [31:0] mon_act;

  // Reference model state
  logic [31:0] mem_model [DEPTH];
  logic [31:0] lc_model = 0;
  logic [31:0] fc_model = 0;
  bit          run_model = 0;
  bit          fault_model = 0;

  function automatic logic [31:0] actual(input int k);
    case (k)
      0:  return d1;
      1:  return {31'b0, fault1};
      2:  return d3;
      3:  return {31'b0, fault3};
      4:  return {31'b0, run1};
      5:  return {31'b0, ready1};
      6:  return {21'b0, lc1};
      7:  return fc1;
      8:  return fc3;
      9:  return {31'b0, run3};
      10: return {21'b0, lc3};
      11: return {31'b0, ready3};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checks++;
        mon_act = actual(sb[i].kind);
        if (mon_act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %h, expected %h", sb[i].name, cyc, mon_act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (drain_check && !drain_done) begin
      drain_done = 1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int kind, input logic [31:0] val, input int dly, input string nm);
    exp_t e;
    e.due = cyc + dly; e.kind = kind; e.val = val; e.name = nm;
    sb.push_back(e);
  endtask

  // Drop expectations that a reset or reload flush makes void.
  task automatic flush_pending();
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > cyc) sb.delete(i);
  endtask

  task automatic check_state();
    expect_at(4,  {31'b0, run_model},  0, "run_l1");
    expect_at(9,  {31'b0, run_model},  0, "run_l3");
    expect_at(5,  {31'b0, !run_model}, 0, "ready_l1");
    expect_at(11, {31'b0, !run_model}, 0, "ready_l3");
    expect_at(6,  lc_model, 0, "lcnt_l1");
    expect_at(10, lc_model, 0, "lcnt_l3");
  endtask

  task automatic check_idle_outputs();
    expect_at(0, 32'h0, 0, "data_l1_zero");
    expect_at(2, 32'h0, 0, "data_l3_zero");
    expect_at(1, {31'b0, fault_model}, 0, "fault_l1");
    expect_at(3, {31'b0, fault_model}, 0, "fault_l3");
    expect_at(7, fc_model, 0, "fcnt_l1");
    expect_at(8, fc_model, 0, "fcnt_l3");
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    load_valid = 1; load_data = d; load_last = last;
    mem_model[lc_model[9:0]] = d;
    lc_model = lc_model + 1;
    if (last || lc_model == DEPTH) run_model = 1;
    step();
    load_valid = 0; load_last = 0;
    check_state();
    expect_at(0, 32'h0, 0, "load_data_l1");
    expect_at(2, 32'h0, 0, "load_data_l3");
  endtask

  task automatic push_fetch(input logic [31:0] a);
    logic [31:0] exp_d;
    bit oor;
    data_bus_addr = a;
    oor   = (a >= lc_model);
    exp_d = oor ? 32'h0 : mem_model[a[9:0]];
    fault_model = fault_model | oor;
    if (!oor) fc_model = fc_model + 1;
    expect_at(0, exp_d, 1, "data_l1");
    expect_at(1, {31'b0, fault_model}, 1, "fault_l1");
    expect_at(2, exp_d, 3, "data_l3");
    expect_at(3, {31'b0, fault_model}, 3, "fault_l3");
    expect_at(7, fc_model, 1, "fcnt_l1");
    expect_at(8, fc_model, 1, "fcnt_l3");
    step();
  endtask

  task automatic do_reset();
    reset = 0;
    flush_pending();
    step();
    reset = 1;
    run_model = 0; lc_model = 0; fault_model = 0; fc_model = 0;
    check_state();
    check_idle_outputs();
  endtask

  initial begin
    reset = 0; data_bus_addr = 0; load_valid = 0; load_data = 0; load_last = 0; reload = 0;
    repeat (5) step();
    check_state();
    check_idle_outputs();
    reset = 1;

    // Three-word image; the address is ignored while loading.
    data_bus_addr = 1;
    load_word(32'h1111_1111, 0);
    load_word(32'h2222_2222, 0);
    load_word(32'h3333_3333, 1);

    // Back-to-back fetches, then out-of-range fetches, then in-range again.
    push_fetch(0); push_fetch(1); push_fetch(2); push_fetch(1);
    push_fetch(3); push_fetch(32'h0000_1000);
    push_fetch(0); push_fetch(2); push_fetch(1);

    // Reset during a fetch, then a reset during a load.
    do_reset();
    load_word(32'hAAAA_0001, 0);
    load_word(32'hAAAA_0002, 0);
    do_reset();

    // Full load without load_last.
    data_bus_addr = 5;
    for (int i = 0; i < DEPTH; i++) load_word(32'hC0DE_0000 | i, 0);

    // load_valid in RUN is ignored.
    load_valid = 1; load_data = 32'hFFFF_FFFF;
    push_fetch(0);
    expect_at(6, 32'd1024, 0, "lcnt_l1_run_ignore");
    load_valid = 0;
    push_fetch(1023);
    push_fetch(1024);
    push_fetch(32'h0001_0005);   // aliases word 5 if the upper address bits were dropped
    push_fetch(5); push_fetch(6); push_fetch(7); push_fetch(8);

`ifdef IMEM_RELOAD_EN
    reload = 1; data_bus_addr = 2;
    flush_pending();
    step();
    reload = 0;
    run_model = 0; lc_model = 0;
    check_state();
    check_idle_outputs();
    step();
    check_state();
    check_idle_outputs();
    // reload while in LOAD does nothing.
    reload = 1;
    step();
    reload = 0;
    check_state();
    load_word(32'h7777_7777, 1);
    push_fetch(0);
    push_fetch(1);                // written earlier, but unloaded since the reload
    push_fetch(0);
`else
    reload = 1;
    push_fetch(3);
    check_state();
    reload = 0;
    push_fetch(1023);
`endif

    repeat (4) step();
    drain_check = 1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-fetch data bus.
- Accepts a program image over a valid/ready load port, then releases the core (`run`).
- While running, returns the word at the fetch address presented by the frontend after a fixed, parameterised latency.
- Replaces the behavioural memory model in bench and FPGA builds.

Parameters:
- DATA_BUS_DATA_BITS, 32, fetch/load word width.
- DATA_BUS_ADDR_BITS, 32, fetch address width (word addressed).
- MEMORY_DEPTH, 1024, words of storage; power of two, at least 4.
- READ_LATENCY, 1, cycles from address sample to data; legal 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a clock edge resets all state.
- data_bus_addr  in  DATA_BUS_ADDR_BITS  fetch address from frontend, sampled every cycle.
- data_bus_data  out  DATA_BUS_DATA_BITS  fetched word.
- load_valid  in  1  load word present.
- load_ready  out  1  responder accepts load word.
- load_data  in  DATA_BUS_DATA_BITS  load word.
- load_last  in  1  final word of image; qualified by load_valid.
- reload  in  1  return to LOAD (only with optional feature).
- run  out  1  image loaded; core may fetch.
- fault  out  1  sticky; fetch of an unloaded or out-of-range address occurred.
- load_count  out  log2(MEMORY_DEPTH)+1  words loaded.
- fetch_count  out  32  accepted in-range fetches in RUN, saturating.

Behaviour:
- Reset values: state=LOAD, load_ready=1, run=0, fault=0, load_count=0, fetch_count=0, data_bus_data=0, read pipeline cleared to 0. Storage array is not cleared.
- States:
  - LOAD: load_ready=1, run=0.
  - RUN: load_ready=0, run=1.
- Load handshake: a transfer occurs when load_valid && load_ready at a clock edge.
  - Write mem[load_count] = load_data, then load_count+1.
  - Producer holds load_data/load_last stable until the handshake.
- LOAD -> RUN on the edge of a transfer with load_last=1, or on the transfer that makes load_count == MEMORY_DEPTH (implicit last).
  - run=1 and load_ready=0 from the following cycle.
  - load_valid in RUN is ignored.
- LOAD with zero words: no transition; run stays 0.
- In LOAD, data_bus_addr is ignored and zeros enter the read pipeline; data_bus_data stays 0.
- RUN fetch: the address sampled at edge N yields data_bus_data = mem[addr] valid after edge N+READ_LATENCY-1.
  - READ_LATENCY=1 means registered output next cycle.
  - A new address is accepted every cycle; fully pipelined, no stalls.
- Address range: addr >= load_count (which includes addr >= MEMORY_DEPTH) returns 0 at normal latency and sets fault from the same cycle that zero appears.
  - No address wrap-around: upper address bits are compared, never truncated.
- fetch_count increments once per in-range RUN sample and saturates at 0xFFFFFFFF.
- Reset mid-load: image abandoned and load_count=0. Previously written words are treated as unloaded and fault if fetched after a reload.
- Reset mid-fetch: in-flight pipeline words discarded; data_bus_data=0 on the next cycle.
- fault clears only on reset.

Optional Feature:
- IMEM_RELOAD_EN defined: reload=1 at an edge while in RUN does the following on that edge:
  - state returns to LOAD;
  - load_count=0;
  - read pipeline flushed to 0;
  - fault and fetch_count preserved;
  - run=0 the next cycle.
- reload in LOAD is ignored.
- IMEM_RELOAD_EN undefined: the reload port exists but is ignored; RUN is left only by reset.

Test Plan:
- Reset held 0 for 5 edges, then 1 → load_ready=1, run=0, data_bus_data=0, fault=0, load_count=0.
- Load 0x11111111, 0x22222222, 0x33333333 (last on third), load_valid held for 3 cycles → load_count=3; run=1 the cycle after the third handshake; load_ready=0.
- READ_LATENCY=1, RUN, addr sequence 0,1,2,1 on consecutive cycles → data 0x11111111, 0x22222222, 0x33333333, 0x22222222 one cycle later each; fetch_count=4; fault=0.
- READ_LATENCY=3 same sequence → identical data shifted 3 cycles; back-to-back with no bubbles.
- Fetch addr 3, then 0x00001000 → 0 returned for both; fault=1 from first zero; fetch_count unchanged; fault stays 1 over further valid fetches.
- Reset driven 0 for one edge mid-load after 2 words → load_count=0, load_ready=1; full 1024-word load without load_last → run=1 after word 1024. With IMEM_RELOAD_EN: reload pulse in RUN → run=0 the next cycle, load_count=0, fetch_count kept.
